// File: rtl/gate_input_conditioner.sv
// -----------------------------------------------------------------------------
// gate_input_conditioner
//
// Front-end for the digital-gates block. Each raw, asynchronous, bouncy pin
// level is brought into the clk domain through a two-flop synchronizer and then
// debounced: a synchronized value has to disagree with the accepted level for
// DEBOUNCE_CYCLES consecutive cycles before it is taken. Any bounce restarts
// the count from zero. Every acceptance produces a one-cycle rise or fall
// strobe on that channel and a shared one-cycle changed strobe.
//
// Parameters:
//   WIDTH            number of independent channels (bit 0 = a, bit 1 = b)
//   DEBOUNCE_CYCLES  consecutive disagreeing cycles needed to accept (1..255)
//
// Ports:
//   clk        system clock, all logic on the rising edge
//   rst        synchronous reset, active-high
//   raw_in     asynchronous raw pin levels
//   enable     1 = debounce active, 0 = freeze clean_out and clear counters
//   clean_out  debounced level per channel (gate operand bits)
//   rise       one-cycle strobe, channel accepted 0->1
//   fall       one-cycle strobe, channel accepted 1->0
//   changed    one-cycle strobe, OR of all rise|fall bits
//   busy       1 while any channel has a transition pending (counter != 0)
// -----------------------------------------------------------------------------
module gate_input_conditioner #(
  parameter int WIDTH           = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] raw_in,
  input  logic             enable,
  output logic [WIDTH-1:0] clean_out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             changed,
  output logic             busy
);

  localparam int              CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync_1;
  logic [WIDTH-1:0] sync_2;
  logic [CW-1:0]    cnt      [WIDTH];
  logic [CW-1:0]    cnt_next [WIDTH];
  logic [WIDTH-1:0] accept;
  logic             busy_next;

  // Next-state for the debounce counters. A channel is accepted on the edge
  // where its counter already holds DEBOUNCE_CYCLES-1 and the synchronized
  // level still disagrees; that same edge updates clean_out and fires the
  // strobe, so the strobe lines up with the first cycle of the new level.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no path leaves
    // it unassigned; a missing default would infer a latch.
    accept    = '0;
    busy_next = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_next[i] = '0;
      if (enable && (sync_2[i] != clean_out[i])) begin
        if (cnt[i] == CNT_LAST) begin
          accept[i] = 1'b1;
        end else begin
          cnt_next[i] = cnt[i] + CW'(1);
        end
      end
      // busy is registered from the next counter value so it tracks the
      // counter register exactly rather than lagging it by a cycle.
      busy_next = busy_next | (cnt_next[i] != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_1    <= '0;
      sync_2    <= '0;
      clean_out <= '0;
      rise      <= '0;
      fall      <= '0;
      changed   <= 1'b0;
      busy      <= 1'b0;
      // NOTE: the counter array is state, not storage; it must be reset so a
      // transition pending at reset time is discarded rather than completed.
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments throughout, so sync_2 takes the old
      // sync_1 and the chain really is two flops deep.
      sync_1    <= raw_in;
      sync_2    <= sync_1;
      clean_out <= clean_out ^ accept;
      rise      <= accept & sync_2;
      fall      <= accept & ~sync_2;
      changed   <= |accept;
      busy      <= busy_next;
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= cnt_next[i];
      end
    end
  end

endmodule

// File: tb/tb_gate_input_conditioner.sv
// -----------------------------------------------------------------------------
// tb_gate_input_conditioner
//
// Directed bench for gate_input_conditioner. The main instance uses the
// default DEBOUNCE_CYCLES=4; a second instance with DEBOUNCE_CYCLES=1 shares
// the same stimulus and is checked for the minimum-latency case. Inputs are
// driven 1 ns after a rising edge and outputs are sampled at that same point,
// so "after edge k" means the value observed following the k-th rising edge
// since the stimulus change.
// -----------------------------------------------------------------------------
module tb_gate_input_conditioner;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] raw_in;
  logic       enable;

  logic [1:0] clean_out, rise, fall;
  logic       changed, busy;

  logic [1:0] clean_out_1, rise_1, fall_1;
  logic       changed_1, busy_1;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  gate_input_conditioner #(.WIDTH(2), .DEBOUNCE_CYCLES(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .raw_in    (raw_in),
    .enable    (enable),
    .clean_out (clean_out),
    .rise      (rise),
    .fall      (fall),
    .changed   (changed),
    .busy      (busy)
  );

  gate_input_conditioner #(.WIDTH(2), .DEBOUNCE_CYCLES(1)) dut_fast (
    .clk       (clk),
    .rst       (rst),
    .raw_in    (raw_in),
    .enable    (enable),
    .clean_out (clean_out_1),
    .rise      (rise_1),
    .fall      (fall_1),
    .changed   (changed_1),
    .busy      (busy_1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_outs(input string tag, input logic [1:0] c, input logic [1:0] r,
                            input logic [1:0] f, input logic ch, input logic b);
    check({tag, ".clean"},   32'(clean_out), 32'(c));
    check({tag, ".rise"},    32'(rise),      32'(r));
    check({tag, ".fall"},    32'(fall),      32'(f));
    check({tag, ".changed"}, 32'(changed),   32'(ch));
    check({tag, ".busy"},    32'(busy),      32'(b));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst    = 1'b1;
    raw_in = 2'b00;
    enable = 1'b1;

    // 1. Reset, then 20 quiet cycles.
    tick();
    tick();
    check_outs("t1_reset", 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
    rst = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      check_outs($sformatf("t1_idle_e%0d", k), 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
    end

    // 2. 00 -> 01 held. D=4: accepted after edge 6, busy after edges 3..5.
    //    D=1: accepted after edge 3, never busy.
    raw_in = 2'b01;
    for (int k = 1; k <= 7; k++) begin
      tick();
      check_outs($sformatf("t2_e%0d", k),
                 (k >= 6) ? 2'b01 : 2'b00,
                 (k == 6) ? 2'b01 : 2'b00,
                 2'b00,
                 (k == 6),
                 (k >= 3 && k <= 5));
      check($sformatf("t2_fast_e%0d.clean", k),   32'(clean_out_1), (k >= 3) ? 32'h1 : 32'h0);
      check($sformatf("t2_fast_e%0d.rise", k),    32'(rise_1),      (k == 3) ? 32'h1 : 32'h0);
      check($sformatf("t2_fast_e%0d.changed", k), 32'(changed_1),   (k == 3) ? 32'h1 : 32'h0);
      check($sformatf("t2_fast_e%0d.busy", k),    32'(busy_1),      32'h0);
    end

    // 3. Bounce on bit 0: 1,0,1 then 0 held (stable 0 starts before edge 4).
    //    Counter hits 1 after edge 4, clears at 5, restarts at 6, accepts at 9.
    for (int k = 1; k <= 10; k++) begin
      raw_in = (k == 2 || k >= 4) ? 2'b00 : 2'b01;
      tick();
      check_outs($sformatf("t3_e%0d", k),
                 (k >= 9) ? 2'b00 : 2'b01,
                 2'b00,
                 (k == 9) ? 2'b01 : 2'b00,
                 (k == 9),
                 (k == 4) || (k >= 6 && k <= 8));
    end

    // 4. Both channels step 00 -> 11 together: one shared acceptance edge.
    raw_in = 2'b11;
    for (int k = 1; k <= 7; k++) begin
      tick();
      check_outs($sformatf("t4_e%0d", k),
                 (k >= 6) ? 2'b11 : 2'b00,
                 (k == 6) ? 2'b11 : 2'b00,
                 2'b00,
                 (k == 6),
                 (k >= 3 && k <= 5));
    end

    // Back to 00: both fall on the same edge.
    raw_in = 2'b00;
    for (int k = 1; k <= 7; k++) begin
      tick();
      check_outs($sformatf("t4b_e%0d", k),
                 (k >= 6) ? 2'b00 : 2'b11,
                 2'b00,
                 (k == 6) ? 2'b11 : 2'b00,
                 (k == 6),
                 (k >= 3 && k <= 5));
    end

    // 5. Glitch: bit 1 high for 3 cycles. Counter reaches 3 then clears.
    for (int k = 1; k <= 8; k++) begin
      raw_in = (k <= 3) ? 2'b10 : 2'b00;
      tick();
      check_outs($sformatf("t5_e%0d", k), 2'b00, 2'b00, 2'b00, 1'b0,
                 (k >= 3 && k <= 5));
    end

    // 6a. Reset at edge 4 of a 00 -> 01 step discards it.
    raw_in = 2'b01;
    for (int k = 1; k <= 3; k++) begin
      tick();
      check_outs($sformatf("t6a_pre_e%0d", k), 2'b00, 2'b00, 2'b00, 1'b0, (k == 3));
    end
    rst = 1'b1;
    tick();
    check_outs("t6a_rst", 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
    rst = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      tick();
      check_outs($sformatf("t6a_post_e%0d", k),
                 (k >= 6) ? 2'b01 : 2'b00,
                 (k == 6) ? 2'b01 : 2'b00,
                 2'b00,
                 (k == 6),
                 (k >= 3 && k <= 5));
    end

    // Return to 00 before the enable case.
    raw_in = 2'b00;
    repeat (8) tick();
    check_outs("t6_settle", 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);

    // 6b. enable=0 at edge 4 clears the count; after re-enable the synchronized
    //     level is already present, so acceptance comes 4 edges later.
    raw_in = 2'b01;
    repeat (3) tick();
    check_outs("t6b_pre", 2'b00, 2'b00, 2'b00, 1'b0, 1'b1);
    enable = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      check_outs($sformatf("t6b_off_e%0d", k), 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
    end
    enable = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      check_outs($sformatf("t6b_on_e%0d", k),
                 (k >= 4) ? 2'b01 : 2'b00,
                 (k == 4) ? 2'b01 : 2'b00,
                 2'b00,
                 (k == 4),
                 (k <= 3));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
